// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide engine: op codes, FSM states, stall levels.
// No logic of its own; pure definitions plus two op-decoding helpers.
// Backpressure: n/a.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE    = 2'b00,
        MD_MUL_RUN = 2'b01,
        MD_DIV_RUN = 2'b10,
        MD_DONE    = 2'b11
    } md_state_e;

    localparam logic MD_STOP   = 1'b1;
    localparam logic MD_NOSTOP = 1'b0;

    // Bit 1 of the op code selects divide, bit 0 selects the unsigned flavour.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide engine.
// Latency: none (wires only).
// Backpressure: result is held in DONE until ack_i; stallreq_o freezes EX while running.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    import muldiv_unit_pkg::*;

    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] opdata1_i;
    logic [WIDTH-1:0] opdata2_i;
    logic             annul_i;
    logic             ack_i;
    logic             busy_o;
    logic             ready_o;
    logic             stallreq_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i, ack_i,
        input  busy_o, ready_o, stallreq_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i, ack_i,
        output busy_o, ready_o, stallreq_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_unit_iter_core.sv
// Iteration datapath: one shift-add multiply step or one restoring divide step per enable.
// Latency: one cycle per step; o_acc_nxt shows the result of the step about to be taken.
// Backpressure: none; the owning FSM gates i_en.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_load_div,
    input  logic               i_en,
    input  logic               i_div_mode,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc_nxt
);
    // Multiply: r_acc = {partial hi, multiplier shifting out}; r_shf = multiplicand.
    // Divide:   r_acc = {remainder, dividend shifting into quotient}; r_shf = divisor.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_shf;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;

    // Compute the next accumulator value for whichever operation is running.
    always_comb begin
        w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_shf} : '0);
        w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
        w_ge     = (w_rem_sh >= {1'b0, r_shf});
        // When w_ge holds the true difference is below 2^WIDTH, so the wrapped low bits are exact.
        w_sub    = w_rem_sh[WIDTH-1:0] - r_shf;
        if (i_div_mode) begin
            o_acc_nxt = {(w_ge ? w_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
        end else begin
            o_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
        end
    end

    // Load operand magnitudes on accept, then advance one step per enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_shf <= '0;
        end else if (i_load) begin
            if (i_load_div) begin
                r_acc <= {{WIDTH{1'b0}}, i_a};
                r_shf <= i_b;
            end else begin
                r_acc <= {{WIDTH{1'b0}}, i_b};
                r_shf <= i_a;
            end
        end else if (i_en) begin
            r_acc <= o_acc_nxt;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with annul and result hold for the HI/LO path.
// Latency: WIDTH+1 cycles iterative; 1 cycle for single-cycle multiply or divide by zero.
// Backpressure: result held in DONE until ack_i; stallreq_o freezes EX while accepting/running.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 1
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_div;
    logic               w_s1;
    logic               w_s2;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic               w_div0;
    logic               w_accept;
    logic               w_busy;
    logic               w_run_en;
    logic               w_last;
    logic [2*WIDTH-1:0] w_core_nxt;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [2*WIDTH-1:0] w_fast_fix;
    logic [2*WIDTH-1:0] w_iter_fix;

    // Operand decode, magnitudes and the sign fix applied to finished results.
    always_comb begin
        w_is_div    = op_is_div(bus.op_i);
        w_s1        = op_is_signed(bus.op_i) & bus.opdata1_i[WIDTH-1];
        w_s2        = op_is_signed(bus.op_i) & bus.opdata2_i[WIDTH-1];
        w_mag1      = w_s1 ? -bus.opdata1_i : bus.opdata1_i;
        w_mag2      = w_s2 ? -bus.opdata2_i : bus.opdata2_i;
        w_div0      = (bus.opdata2_i == '0);
        w_accept    = (r_state == MD_IDLE) & bus.start_i & ~bus.annul_i;
        w_busy      = (r_state == MD_MUL_RUN) | (r_state == MD_DIV_RUN);
        w_run_en    = w_busy & ~bus.annul_i;
        w_last      = (r_cnt == CNT_W'(WIDTH - 1));
        w_fast_prod = {{WIDTH{1'b0}}, w_mag1} * {{WIDTH{1'b0}}, w_mag2};
        w_fast_fix  = (w_s1 ^ w_s2) ? -w_fast_prod : w_fast_prod;
        if (r_state == MD_DIV_RUN) begin
            // Remainder follows the dividend sign, quotient the xor of both signs.
            w_iter_fix = {(r_sign_r ? -w_core_nxt[2*WIDTH-1:WIDTH] : w_core_nxt[2*WIDTH-1:WIDTH]),
                          (r_sign_q ? -w_core_nxt[WIDTH-1:0]       : w_core_nxt[WIDTH-1:0])};
        end else begin
            w_iter_fix = r_sign_q ? -w_core_nxt : w_core_nxt;
        end
    end

    muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_div (w_is_div),
        .i_en       (w_run_en),
        .i_div_mode (r_state == MD_DIV_RUN),
        .i_a        (w_mag1),
        .i_b        (w_mag2),
        .o_acc_nxt  (w_core_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= MD_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: annul wins everywhere outside IDLE and also blocks a same-cycle start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: begin
                if (w_accept) begin
                    if (w_is_div)           w_state_nxt = w_div0 ? MD_DONE : MD_DIV_RUN;
                    else if (MUL_ITER != 0) w_state_nxt = MD_MUL_RUN;
                    else                    w_state_nxt = MD_DONE;
                end
            end
            MD_MUL_RUN, MD_DIV_RUN: begin
                if (bus.annul_i)  w_state_nxt = MD_IDLE;
                else if (w_last)  w_state_nxt = MD_DONE;
            end
            MD_DONE: begin
                if (bus.annul_i | bus.ack_i) w_state_nxt = MD_IDLE;
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Counter, latched signs and the HI/LO result registers (held across DONE and annul).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_sign_q <= w_s1 ^ w_s2;
            r_sign_r <= w_s1;
            if (w_is_div && w_div0) begin
                r_lo <= '1;
                r_hi <= bus.opdata1_i;
            end else if (!w_is_div && MUL_ITER == 0) begin
                {r_hi, r_lo} <= w_fast_fix;
            end
        end else if (w_run_en) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) {r_hi, r_lo} <= w_iter_fix;
        end
    end

    assign bus.busy_o     = w_busy;
    assign bus.ready_o    = (r_state == MD_DONE);
    assign bus.stallreq_o = (w_accept | w_busy) ? MD_STOP : MD_NOSTOP;
    assign bus.hi_o       = r_hi;
    assign bus.lo_o       = r_lo;
endmodule
